inst_encoder: RTL
=================

// Module: inst_encoder
// PURPOSE
//  Field-level to 32-bit RV32I instruction encoder; inverse of the ID-stage decode path.
//  Requests arrive as (op, rd, rs1, rs2, imm); encoded words leave through a DEPTH-entry
//  FIFO over valid/ready. Feeds BIOS/test instruction injection into fetch.
//  Sticky error flags catch illegal ops and out-of-range immediates.
// PARAMETERS
//  DEPTH  2   output FIFO entries (power of 2, >=2)
//  CNT_W  16  width of emitted-instruction counter
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   encoder can accept (FIFO not full)
//  req_op     in   6   op enum (see BEHAVIOUR)
//  req_rd     in   5   destination register
//  req_rs1    in   5   source 1
//  req_rs2    in   5   source 2
//  req_imm    in   32  immediate, byte offset, two's complement
//  inst_valid out  1   FIFO head valid
//  inst_ready in   1   consumer accepts head
//  inst       out  32  encoded instruction at FIFO head
//  err_op     out  1   sticky: illegal op seen
//  err_imm    out  1   sticky: immediate out of range seen
//  err_clr    in   1   synchronous clear of both sticky flags
//  inst_count out  CNT_W  number of words popped, wraps to 0
// BEHAVIOUR
//  - One clock, asynchronous active-low reset (clk, rst_n). Reset: FIFO empty, inst_valid=0,
//    inst=0, err_op=0, err_imm=0, inst_count=0; req_ready=1 once rst_n deasserts.
//    Reset mid-stream discards all queued words.
//  - Op enum: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 ADDI,11 SLTI,
//    12 SLTIU,13 XORI,14 ORI,15 ANDI,16 SLLI,17 SRLI,18 SRAI,19 LB,20 LH,21 LW,22 LBU,
//    23 LHU,24 SB,25 SH,26 SW,27 BEQ,28 BNE,29 BLT,30 BGE,31 BLTU,32 BGEU,33 JAL,34 JALR,
//    35 LUI,36 AUIPC. Ops 37-63 illegal.
//  - Accept = req_valid & req_ready; req_ready = (count < DEPTH), combinational from count.
//    When full, no push even if a pop occurs in the same cycle.
//  - Encoding is combinational at accept; the word is written into the FIFO that edge.
//    Latency: accept in cycle N -> inst_valid=1 in cycle N+1 (empty FIFO).
//  - Pop = inst_valid & inst_ready. Push and pop in the same cycle: count unchanged.
//    inst holds stable while inst_valid & !inst_ready.
//  - Unused fields are forced to 0 (e.g. rs2 for I-type, rd for S/B). SRA/SRAI set inst[30].
//  - Imm ranges: I/S/JALR signed 12b; B signed 13b, bit0=0; J signed 21b, bit0=0;
//    U (LUI/AUIPC) imm[11:0]=0, imm[31:12] used; shifts 0..31.
//  - Out-of-range imm: encode truncated bits, push anyway, set err_imm.
//  - Illegal op: accepted (handshake completes), nothing pushed, err_op set.
//  - err_clr and a new error in the same cycle: flag ends set (set wins).
//  - inst_count += 1 per pop, wraps modulo 2^CNT_W.
// TESTING
//  1 ADDI rd=1 rs1=0 imm=5 -> inst=0x00500093 one cycle after accept, err flags 0.
//  2 ADD rd=3 rs1=1 rs2=2 then SUB same fields -> 0x002081B3 then 0x402081B3, in order.
//  3 BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; LUI rd=5 imm=0x12345000 -> 0x123452B7.
//  4 inst_ready=0, push 3 reqs -> req_ready=0 after DEPTH=2 pushes; release ->
//    both words pop in order, inst_count=2, third request then accepted.
//  5 op=40 -> handshake completes, FIFO stays empty, err_op=1 until err_clr pulse.
//    ADDI imm=4096 -> word pushed, err_imm=1.
//  6 Assert rst_n=0 with 2 words queued -> inst_valid=0, inst_count=0 asynchronously;
//    after release, ADDI x1,x0,5 encodes correctly.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I field-level instruction encoder feeding a small valid/ready output FIFO.
// Illegal ops and out-of-range immediates raise sticky error flags.
module inst_encoder #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_op,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [31:0]      req_imm,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic             err_op,
    output logic             err_imm,
    input  logic             err_clr,
    output logic [CNT_W-1:0] inst_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {FmtR, FmtI, FmtSh, FmtS, FmtB, FmtU, FmtJ} fmt_e;

    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        op_legal;
    logic        imm_ok;
    logic [31:0] word;

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] inst_count_q, inst_count_d;
    logic             err_op_q, err_op_d;
    logic             err_imm_q, err_imm_d;
    logic             accept, push, pop;

    // Op decode: instruction format, major opcode and function fields.
    always_comb begin
        fmt      = FmtR;
        opcode   = 7'h33;
        f3       = 3'd0;
        f7       = 7'h00;
        op_legal = 1'b1;
        case (req_op)
            6'd0:  f3 = 3'd0;
            6'd1:  begin f3 = 3'd0; f7 = 7'h20; end
            6'd2:  f3 = 3'd1;
            6'd3:  f3 = 3'd2;
            6'd4:  f3 = 3'd3;
            6'd5:  f3 = 3'd4;
            6'd6:  f3 = 3'd5;
            6'd7:  begin f3 = 3'd5; f7 = 7'h20; end
            6'd8:  f3 = 3'd6;
            6'd9:  f3 = 3'd7;
            6'd10: begin fmt = FmtI; opcode = 7'h13; f3 = 3'd0; end
            6'd11: begin fmt = FmtI; opcode = 7'h13; f3 = 3'd2; end
            6'd12: begin fmt = FmtI; opcode = 7'h13; f3 = 3'd3; end
            6'd13: begin fmt = FmtI; opcode = 7'h13; f3 = 3'd4; end
            6'd14: begin fmt = FmtI; opcode = 7'h13; f3 = 3'd6; end
            6'd15: begin fmt = FmtI; opcode = 7'h13; f3 = 3'd7; end
            6'd16: begin fmt = FmtSh; opcode = 7'h13; f3 = 3'd1; end
            6'd17: begin fmt = FmtSh; opcode = 7'h13; f3 = 3'd5; end
            6'd18: begin fmt = FmtSh; opcode = 7'h13; f3 = 3'd5; f7 = 7'h20; end
            6'd19: begin fmt = FmtI; opcode = 7'h03; f3 = 3'd0; end
            6'd20: begin fmt = FmtI; opcode = 7'h03; f3 = 3'd1; end
            6'd21: begin fmt = FmtI; opcode = 7'h03; f3 = 3'd2; end
            6'd22: begin fmt = FmtI; opcode = 7'h03; f3 = 3'd4; end
            6'd23: begin fmt = FmtI; opcode = 7'h03; f3 = 3'd5; end
            6'd24: begin fmt = FmtS; opcode = 7'h23; f3 = 3'd0; end
            6'd25: begin fmt = FmtS; opcode = 7'h23; f3 = 3'd1; end
            6'd26: begin fmt = FmtS; opcode = 7'h23; f3 = 3'd2; end
            6'd27: begin fmt = FmtB; opcode = 7'h63; f3 = 3'd0; end
            6'd28: begin fmt = FmtB; opcode = 7'h63; f3 = 3'd1; end
            6'd29: begin fmt = FmtB; opcode = 7'h63; f3 = 3'd4; end
            6'd30: begin fmt = FmtB; opcode = 7'h63; f3 = 3'd5; end
            6'd31: begin fmt = FmtB; opcode = 7'h63; f3 = 3'd6; end
            6'd32: begin fmt = FmtB; opcode = 7'h63; f3 = 3'd7; end
            6'd33: begin fmt = FmtJ; opcode = 7'h6F; end
            6'd34: begin fmt = FmtI; opcode = 7'h67; f3 = 3'd0; end
            6'd35: begin fmt = FmtU; opcode = 7'h37; end
            6'd36: begin fmt = FmtU; opcode = 7'h17; end
            default: op_legal = 1'b0;
        endcase
    end

    // Field assembly; out-of-range immediates still encode their truncated bits.
    always_comb begin
        word   = '0;
        imm_ok = 1'b1;
        case (fmt)
            FmtR: word = {f7, req_rs2, req_rs1, f3, req_rd, opcode};
            FmtI: begin
                word   = {req_imm[11:0], req_rs1, f3, req_rd, opcode};
                imm_ok = (&req_imm[31:11]) | ~(|req_imm[31:11]);
            end
            FmtSh: begin
                word   = {f7, req_imm[4:0], req_rs1, f3, req_rd, opcode};
                imm_ok = ~(|req_imm[31:5]);
            end
            FmtS: begin
                word   = {req_imm[11:5], req_rs2, req_rs1, f3, req_imm[4:0], opcode};
                imm_ok = (&req_imm[31:11]) | ~(|req_imm[31:11]);
            end
            FmtB: begin
                word   = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, f3,
                          req_imm[4:1], req_imm[11], opcode};
                imm_ok = ((&req_imm[31:12]) | ~(|req_imm[31:12])) & ~req_imm[0];
            end
            FmtU: begin
                word   = {req_imm[31:12], req_rd, opcode};
                imm_ok = ~(|req_imm[11:0]);
            end
            FmtJ: begin
                word   = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, opcode};
                imm_ok = ((&req_imm[31:20]) | ~(|req_imm[31:20])) & ~req_imm[0];
            end
            default: word = '0;
        endcase
    end

    assign req_ready  = (count_q < CW'(DEPTH));
    assign inst_valid = (count_q != '0);
    assign accept     = req_valid & req_ready;
    assign push       = accept & op_legal;
    assign pop        = inst_valid & inst_ready;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = word;
        end
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        count_d      = count_q + CW'(push) - CW'(pop);
        inst_count_d = inst_count_q + CNT_W'(pop);
        // A new error in the same cycle as err_clr leaves the flag set.
        err_op_d     = (err_op_q & ~err_clr) | (accept & ~op_legal);
        err_imm_d    = (err_imm_q & ~err_clr) | (push & ~imm_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inst_count_q <= '0;
            err_op_q     <= 1'b0;
            err_imm_q    <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inst_count_q <= inst_count_d;
            err_op_q     <= err_op_d;
            err_imm_q    <= err_imm_d;
        end
    end

    assign inst       = inst_valid ? mem_q[rd_ptr_q] : '0;
    assign err_op     = err_op_q;
    assign err_imm    = err_imm_q;
    assign inst_count = inst_count_q;

endmodule
